// File: rtl/mul_seq_if.sv
// Request/result bundle between the CPU pipeline and the sequential multiplier.
// The CPU drives operands and start; the multiplier returns the product and busy.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (output start, output sign, output a, output b,
                  input  hi,    input  lo,   input  busy);
  modport slave  (input  start, input  sign, input  a,  input  b,
                  output hi,    output lo,   output busy);
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add 32x32 multiplier for MULT/MULTU: magnitudes are multiplied over
// WIDTH iterations, then a single fix-up edge applies the sign and writes hi/lo.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mul_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mc, mc_nxt;
  logic [WIDTH-1:0]   mp, mp_nxt;
  logic [WIDTH:0]     acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               neg, neg_nxt;
  logic [WIDTH-1:0]   hi, hi_nxt;
  logic [WIDTH-1:0]   lo, lo_nxt;
  logic               busy, busy_nxt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Two's-complement magnitude; the most negative value maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Next-state and datapath: every register holds unless its state updates it.
  always_comb begin
    state_nxt = state;
    mc_nxt    = mc;
    mp_nxt    = mp;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    neg_nxt   = neg;
    hi_nxt    = hi;
    lo_nxt    = lo;
    busy_nxt  = busy;
    sum       = {(WIDTH+1){1'b0}};
    prod      = {(2*WIDTH){1'b0}};
    case (state)
      IDLE: begin
        if (bus.start) begin
          mc_nxt    = magnitude(bus.a, bus.sign);
          mp_nxt    = magnitude(bus.b, bus.sign);
          neg_nxt   = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_nxt   = {(WIDTH+1){1'b0}};
          cnt_nxt   = {CNT_W{1'b0}};
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        sum     = acc + (mp[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        // The low sum bit drops into the multiplier register as it shifts out.
        acc_nxt = {1'b0, sum[WIDTH:1]};
        mp_nxt  = {sum[0], mp[WIDTH-1:1]};
        cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt == CNT_W'(WIDTH-1)) begin
          state_nxt = FIX;
        end else begin
          state_nxt = RUN;
        end
      end
      FIX: begin
        prod = {acc[WIDTH-1:0], mp};
        if (neg) begin
          prod = ~prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
          prod = {acc[WIDTH-1:0], mp};
        end
        hi_nxt    = prod[2*WIDTH-1:WIDTH];
        lo_nxt    = prod[WIDTH-1:0];
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register on the falling edge so the CPU samples results on the rising edge.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mc    <= {WIDTH{1'b0}};
      mp    <= {WIDTH{1'b0}};
      acc   <= {(WIDTH+1){1'b0}};
      cnt   <= {CNT_W{1'b0}};
      neg   <= 1'b0;
      hi    <= {WIDTH{1'b0}};
      lo    <= {WIDTH{1'b0}};
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      mc    <= mc_nxt;
      mp    <= mp_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      neg   <= neg_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      busy  <= busy_nxt;
    end
  end

  assign bus.hi   = hi;
  assign bus.lo   = lo;
  assign bus.busy = busy;
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: inputs change and outputs are sampled on the rising
// edge, half a period away from the falling edge the multiplier updates on.
module tb_mul_seq;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  int   n;

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One active (falling) edge, then return to the rising edge for sampling.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  // Steps until busy drops; cnt accumulates edges taken, bounded to avoid hanging.
  task automatic wait_done(inout int cnt);
    while (bus.busy === 1'b1 && cnt < 60) begin
      step();
      cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int k;
    bus.start = 1'b1;
    bus.sign  = sgn;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    check_val({tag, "_busy_e0"}, {63'd0, bus.busy}, 64'd1);
    step();
    check_val({tag, "_hold"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
    k = 1;
    wait_done(k);
    check_val({tag, "_cycles"}, 64'(k), 64'd33);
    check_val({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    check_val({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_hi   = 32'h0;
    prev_lo   = 32'h0;
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    @(posedge clk);
    step();
    step();
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset     = 1'b1;
    bus.start = 1'b0;
    step();
    check_val("rst_no_start", {63'd0, bus.busy}, 64'd0);

    run_op("multu_7x6",   1'b0, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A);
    run_op("multu_max",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m1x5",   1'b1, 32'hFFFF_FFFF,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op("mult_m1xm1",  1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001);
    run_op("mult_min2",   1'b1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000);
    run_op("multu_min2",  1'b0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000);

    // Start while busy: a second request from E10 is held through E33 and must only land at E34.
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 60) begin
      if (n == 9) begin
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
      end
      step();
      n++;
    end
    check_val("busy_ign_cycles", 64'(n), 64'd33);
    check_val("busy_ign_hi", {32'd0, bus.hi}, 64'd0);
    check_val("busy_ign_lo", {32'd0, bus.lo}, 64'd12);
    step();
    bus.start = 1'b0;
    check_val("start_e34", {63'd0, bus.busy}, 64'd1);
    n = 0;
    wait_done(n);
    check_val("b2b_cycles", 64'(n), 64'd33);
    check_val("b2b_prod", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // Reset sampled at E15 discards the in-flight MULT 100*-3.
    bus.start = 1'b1;
    bus.sign  = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'hFFFF_FFFD;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
    end
    check_val("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    step();
    check_val("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    check_val("post_rst_idle", {63'd0, bus.busy}, 64'd0);
    check_val("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    prev_hi = 32'h0;
    prev_lo = 32'h0;
    run_op("mult_100xm3", 1'b1, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FED4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32x32 multiplier for the MIPS54 CPU core, the multiply counterpart of the iterative divider. It serves MULT and MULTU: radix-2 shift-add over magnitudes, followed by a one-cycle sign fix-up, producing a 64-bit product on `hi`/`lo`. The CPU asserts `start` and stalls while `busy` is high. State updates on the falling edge of `clk`, matching the divider, so the CPU samples results on the rising edge.

## Interface
- `WIDTH`, default 32: operand width. The product is 2*`WIDTH`. Only 32 is used by the CPU.
- `clk` input 1: clock. All state updates on its falling edge.
- `reset` input 1: reset, synchronous and active-low. Sampled on the falling edge of `clk`.
- `start` input 1: request a multiply. Ignored while `busy`=1.
- `sign` input 1: 1 selects MULT (signed operands), 0 selects MULTU (unsigned). Latched with `start`.
- `a` input WIDTH: multiplicand. Latched with `start`.
- `b` input WIDTH: multiplier. Latched with `start`.
- `hi` output WIDTH: upper half of the product, registered.
- `lo` output WIDTH: lower half of the product, registered.
- `busy` output 1: operation in progress, registered.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: 32 iterations.
  - FIX: sign correction and result write.
- IDLE, `start`=1:
  - Latch `mc` = |a| and `mp` = |b|. Magnitude is taken only when `sign`=1 and the operand MSB is 1; otherwise the raw value is used.
  - Latch `neg` = `sign` & (a[31]^b[31]).
  - Set `acc[32:0]`=0 and `cnt`=0. Set `busy`=1 and go to RUN.
- IDLE, `start`=0: hold all state.
- RUN, each edge:
  - `sum[32:0]` = `acc` + (`mp`[0] ? {1'b0,`mc`} : 0).
  - Shift right: {`acc`,`mp`} <= {1'b0,`sum`,`mp`[31:1]}. The carry enters `acc`[31], and `sum`[0] enters `mp`[31].
  - `cnt`++. On the edge where `cnt`==31, go to FIX.
- FIX (one edge):
  - `p` = {`acc`[31:0],`mp`}.
  - {`hi`,`lo`} <= `neg` ? (~`p` + 1) : `p`, with the negation done at 64 bits.
  - `busy`<=0 and go to IDLE.
- `hi`/`lo` change only in FIX. They hold the previous result through RUN and until the next FIX.
- `start` in RUN or FIX: ignored, and the latched operands are unaffected.
- Magnitude of 0x80000000 under `sign`=1 is 0x80000000 as unsigned 32-bit. No overflow; the product always fits in 64 bits.
- Zero operands take the full 33-cycle path. There is no early exit.
- `reset`=0 on any edge, in any state:
  - `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, `acc`=0.
  - Reset has priority over `start`.
  - An in-flight result is discarded, and `hi`/`lo` read 0 afterwards.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- Edge E0: `start`=1 sampled in IDLE. `busy`=1 after E0.
- Edges E1..E32: RUN iterations.
- Edge E33: FIX. `hi`/`lo` valid and `busy`=0 after E33.
- `busy` is high for exactly 33 clock periods.
- Earliest next accepted `start` is E34. A `start` held high through E33 is not accepted at E33, because FIX ignores it.
- Back-to-back operations: 34 edges per operation.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive `reset`=0 for 2 edges with `start`=1 -> `busy`=0, `hi`=0, `lo`=0, and no operation starts.
- Unsigned basic and max:
  - MULTU 7*6 -> `busy` high 33 cycles, then `hi`=0x00000000, `lo`=0x0000002A.
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed mixed and both negative:
  - MULT 0xFFFFFFFF(-1)*5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFB.
  - MULT -1*-1 -> `hi`=0, `lo`=1.
- Signed corner: MULT 0x80000000*0x80000000 -> `hi`=0x40000000, `lo`=0. MULTU with the same operands gives the same result.
- Start while busy: start MULTU 3*4, then at E10 drive `start`=1 with `a`=`b`=0xFFFFFFFF -> result `lo`=12, `hi`=0, `busy` still falls after E33.
- Reset mid-operation: start MULT 100*-3, then assert reset at E15 -> `busy`=0, `hi`/`lo`=0. A new MULT 100*-3 started later -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFED4.
